// File: rtl/ram_port_pkg.sv
// rtl/ram_port_pkg.sv - shared constants and FSM state type for the RAM port controller
// Purpose : default RAM geometry and the controller state enum.
// Config  : WR_VERIFY_EN adds the VF_ADDR/VF_DRIVE write-verify states.
package ram_port_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DRIVE
`ifdef WR_VERIFY_EN
        ,
        VF_ADDR,
        VF_DRIVE
`endif
    } state_e;

endpackage

// File: rtl/ram_bus_drv.sv
// rtl/ram_bus_drv.sv - tri-state driver for the shared RAM data bus
// Purpose : drives bus_io from registered enable/data, otherwise releases it.
// Ports   : drive_en_i   - registered drive enable
//           drive_data_i - registered data to place on the bus
//           bus_io       - shared bidirectional data bus
//           sample_o     - current bus value as seen by this port
module ram_bus_drv #(
    parameter int DATA_W = 8
) (
    input  logic              drive_en_i,
    input  logic [DATA_W-1:0] drive_data_i,
    inout  wire  [DATA_W-1:0] bus_io,
    output logic [DATA_W-1:0] sample_o
);

    assign bus_io   = drive_en_i ? drive_data_i : {DATA_W{1'bz}};
    assign sample_o = bus_io;

endmodule

// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - valid/ready request master for one port of the 16x8 dual-port RAM
// Purpose : converts single-word read/write requests into cs/wr_en/out_en/address
//           pin signalling, drives the bus only while writing, returns read data
//           on a one-cycle rsp_valid strobe.
// Config  : WR_VERIFY_EN - read back each written word and pulse rsp_err on mismatch.
// Ports   : clk, rst                  - clock, asynchronous active-high reset
//           req_valid/req_ready       - request handshake
//           req_we/req_addr/req_wdata - request fields
//           rsp_valid/rsp_rdata       - read response strobe and data
//           rsp_err                   - write-verify mismatch strobe
//           ram_cs/ram_wr_en/ram_out_en/ram_addr/ram_data - RAM port pins
module ram_port_ctrl
    import ram_port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_cs,
    output logic              ram_wr_en,
    output logic              ram_out_en,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                cs_q, cs_d;
    logic                wr_en_q, wr_en_d;
    logic                out_en_q, out_en_d;
    logic                drv_en_q, drv_en_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]   bus_sample;
`ifdef WR_VERIFY_EN
    logic                rsp_err_q, rsp_err_d;
`endif

    ram_bus_drv #(
        .DATA_W(DATA_W)
    ) u_bus_drv (
        .drive_en_i  (drv_en_q),
        .drive_data_i(wdata_q),
        .bus_io      (ram_data),
        .sample_o    (bus_sample)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef WR_VERIFY_EN
        rsp_err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WRITE : RD_ADDR;
                end
            end
`ifdef WR_VERIFY_EN
            WRITE:    state_d = VF_ADDR;
`else
            WRITE:    state_d = IDLE;
`endif
            RD_ADDR:  state_d = RD_DRIVE;
            RD_DRIVE: begin
                // The RAM is driving its output register onto the bus this cycle.
                rsp_valid_d = 1'b1;
                rsp_rdata_d = bus_sample;
                state_d     = IDLE;
            end
`ifdef WR_VERIFY_EN
            VF_ADDR:  state_d = VF_DRIVE;
            VF_DRIVE: begin
                rsp_err_d = (bus_sample != wdata_q);
                state_d   = IDLE;
            end
`endif
            default:  state_d = IDLE;
        endcase

        // Pin outputs are registered from the next state, so they line up with
        // state_q in the following cycle. Drive enable and out_en both derive
        // from the same state, so they can never overlap.
        ready_d  = (state_d == IDLE);
        cs_d     = (state_d != IDLE);
        wr_en_d  = (state_d == WRITE);
        drv_en_d = (state_d == WRITE);
`ifdef WR_VERIFY_EN
        out_en_d = (state_d == RD_DRIVE) || (state_d == VF_DRIVE);
`else
        out_en_d = (state_d == RD_DRIVE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            cs_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            out_en_q    <= 1'b0;
            drv_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            cs_q        <= cs_d;
            wr_en_q     <= wr_en_d;
            out_en_q    <= out_en_d;
            drv_en_q    <= drv_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef WR_VERIFY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready  = ready_q;
    assign ram_cs     = cs_q;
    assign ram_wr_en  = wr_en_q;
    assign ram_out_en = out_en_q;
    assign ram_addr   = addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb/tb_ram_port_ctrl.sv - directed self-checking bench for ram_port_ctrl with a RAM port model
module tb_ram_port_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = 4'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       ram_cs;
    logic       ram_wr_en;
    logic       ram_out_en;
    logic [3:0] ram_addr;
    wire  [7:0] ram_data;

    int checks = 0;
    int failures = 0;
    int violations = 0;
    logic [7:0] rsp_log[$];

    // RAM port model: write at edge, output register loads on read-select, drives when out_en.
    logic [7:0] mem [16];
    logic [7:0] ram_q = 8'd0;
    logic       stuck = 1'b0;

    always #5 clk = ~clk;

    ram_port_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_cs    (ram_cs),
        .ram_wr_en (ram_wr_en),
        .ram_out_en(ram_out_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wr_en) mem[ram_addr] <= ram_data;
            else           ram_q <= mem[ram_addr];
        end
    end

    assign ram_data = (ram_cs && ram_out_en) ? (ram_q & ~{7'd0, stuck}) : 8'hzz;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr_en && ram_out_en) violations++;
            if (rsp_valid) rsp_log.push_back(rsp_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d);
        logic rdy;
        logic acc;
        acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            rdy = req_ready;
            cyc();
            if (rdy) begin acc = 1'b1; break; end
        end
        req_valid = 1'b0;
        check("req_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_idle();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin seen = 1'b1; break; end
            cyc();
        end
        check("wait_idle", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_rsp(input logic [7:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            cyc();
        end
        check("rsp_seen", {31'd0, seen}, 32'd1);
        check("rsp_data", {24'd0, rsp_rdata}, {24'd0, exp});
    endtask

    initial begin
        logic rdy;
        logic rv_at_accept;
        int   err_cnt;
        int   val_cnt;
        int   idx;
        logic [7:0] b2b_we;
        logic [3:0] b2b_a [4];
        logic [7:0] b2b_d [4];

        // Reset state
        cyc(); cyc();
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        check("rst_out_en", {31'd0, ram_out_en}, 32'd0);
        check("rst_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        cyc();

        // Write 4 / A5: one-cycle write pulse, bus carries A5 only then
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd4; req_wdata = 8'hA5;
        cyc();
        req_valid = 1'b0;
        check("wr_cs", {31'd0, ram_cs}, 32'd1);
        check("wr_wr_en", {31'd0, ram_wr_en}, 32'd1);
        check("wr_out_en", {31'd0, ram_out_en}, 32'd0);
        check("wr_addr", {28'd0, ram_addr}, 32'd4);
        check("wr_bus", {24'd0, ram_data}, 32'h0000_00A5);
        check("wr_ready", {31'd0, req_ready}, 32'd0);
        cyc();
        check("wr_after_wr_en", {31'd0, ram_wr_en}, 32'd0);
`ifdef WR_VERIFY_EN
        check("wr_vf_ready", {31'd0, req_ready}, 32'd0);
        cyc(); cyc();
`endif
        check("wr_after_ready", {31'd0, req_ready}, 32'd1);
        check("wr_after_cs", {31'd0, ram_cs}, 32'd0);
        check("mem4", {24'd0, mem[4]}, 32'h0000_00A5);

        // Leave different write data latched so a stale bus drive would corrupt the read
        do_req(1'b1, 4'd9, 8'h42);
        wait_idle();

        // Read 4
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
        cyc();
        req_valid = 1'b0;
        check("rd1_cs", {31'd0, ram_cs}, 32'd1);
        check("rd1_wr_en", {31'd0, ram_wr_en}, 32'd0);
        check("rd1_out_en", {31'd0, ram_out_en}, 32'd0);
        check("rd1_ready", {31'd0, req_ready}, 32'd0);
        cyc();
        check("rd2_out_en", {31'd0, ram_out_en}, 32'd1);
        check("rd2_cs", {31'd0, ram_cs}, 32'd1);
        check("rd2_bus", {24'd0, ram_data}, 32'h0000_00A5);
        check("rd2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        cyc();
        check("rd3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd3_rsp_rdata", {24'd0, rsp_rdata}, 32'h0000_00A5);
        check("rd3_ready", {31'd0, req_ready}, 32'd1);
        check("rd3_out_en", {31'd0, ram_out_en}, 32'd0);
        cyc();
        check("rd4_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Back-to-back with req_valid held high
        rsp_log.delete();
        b2b_we = 8'b0000_0101;
        b2b_a[0] = 4'd15; b2b_d[0] = 8'h3C;
        b2b_a[1] = 4'd15; b2b_d[1] = 8'h00;
        b2b_a[2] = 4'd0;  b2b_d[2] = 8'hFF;
        b2b_a[3] = 4'd0;  b2b_d[3] = 8'h00;
        rv_at_accept = 1'b0;
        idx = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && idx < 4; i++) begin
            req_we = b2b_we[idx]; req_addr = b2b_a[idx]; req_wdata = b2b_d[idx];
            rdy = req_ready;
            if (rdy && idx == 2) rv_at_accept = rsp_valid;
            cyc();
            if (rdy) idx++;
        end
        req_valid = 1'b0;
        check("b2b_all_accepted", idx, 32'd4);
        check("b2b_accept_during_rsp", {31'd0, rv_at_accept}, 32'd1);
        for (int i = 0; i < 6; i++) cyc();
        check("b2b_rsp_count", rsp_log.size(), 32'd2);
        if (rsp_log.size() == 2) begin
            check("b2b_rsp0", {24'd0, rsp_log[0]}, 32'h0000_003C);
            check("b2b_rsp1", {24'd0, rsp_log[1]}, 32'h0000_00FF);
        end

        // Reset during RD_DRIVE
        do_req(1'b1, 4'd6, 8'hC3);
        wait_idle();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
        cyc();
        req_valid = 1'b0;
        cyc();
        check("mid_out_en", {31'd0, ram_out_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_cs", {31'd0, ram_cs}, 32'd0);
        check("mid_rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        check("mid_rst_out_en", {31'd0, ram_out_en}, 32'd0);
        check("mid_rst_addr", {28'd0, ram_addr}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        cyc();
        check("mid_rst_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        rst = 1'b0;
        cyc();
        do_req(1'b0, 4'd4, 8'h00);
        wait_rsp(8'hA5);
        wait_idle();

        // Write of 01 with bit 0 stuck low on read-back
        stuck = 1'b1;
        err_cnt = 0;
        val_cnt = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd2; req_wdata = 8'h01;
        cyc();
        req_valid = 1'b0;
        check("vf_wr_ready", {31'd0, req_ready}, 32'd0);
        cyc();
`ifdef WR_VERIFY_EN
        check("vf_busy", {31'd0, req_ready}, 32'd0);
`else
        check("novf_ready_back", {31'd0, req_ready}, 32'd1);
`endif
        for (int i = 0; i < 6; i++) begin
            if (rsp_err) err_cnt++;
            if (rsp_valid) val_cnt++;
            cyc();
        end
`ifdef WR_VERIFY_EN
        check("vf_err_pulses", err_cnt, 32'd1);
`else
        check("novf_err_pulses", err_cnt, 32'd0);
`endif
        check("vf_rsp_valid", val_cnt, 32'd0);
        stuck = 1'b0;

        check("no_wr_oe_overlap", violations, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
